// File: rtl/gf192_pkg.sv
// Shared constants and types for the 192-bit ECDH prime-field blocks.
package gf192_pkg;

    localparam int BW_GF = 192;
    localparam logic [BW_GF-1:0] P_192 =
        192'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF;
    localparam int MAX_ITER = 4 * BW_GF;
    localparam int ITER_W   = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mod_halve_192.sv
// Combinational halve(x) mod P: x/2 for even x, (x+P)/2 for odd x (P odd, so x+P is even).
module mod_halve_192
    import gf192_pkg::*;
(
    input  logic [BW_GF-1:0] x,
    output logic [BW_GF-1:0] y
);

    logic [BW_GF:0] sum;

    always_comb begin
        sum = {1'b0, x} + (x[0] ? {1'b0, P_192} : '0);
        y   = BW_GF'(sum >> 1);
    end

endmodule

// File: rtl/mod_inv_192.sv
// Modular inverse a^-1 mod P via binary extended Euclid, one reduction per clock.
// Optional MOD_INV_CONST_TIME_EN pads every non-error operation to MAX_ITER RUN cycles.
module mod_inv_192
    import gf192_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BW_GF-1:0] a,
    output logic [BW_GF-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    state_t state, state_nxt;

    logic [BW_GF-1:0] u, v, x1, x2;
    logic [BW_GF-1:0] u_nxt, v_nxt, x1_nxt, x2_nxt, out_nxt;
    logic             err_nxt;

    logic [BW_GF-1:0] x1_half, x2_half;
    logic [BW_GF:0]   d12, d21;
    logic [BW_GF-1:0] x1_sub, x2_sub;

    mod_halve_192 u_halve_x1 (.x(x1), .y(x1_half));
    mod_halve_192 u_halve_x2 (.x(x2), .y(x2_half));

    // A borrow out of the extra top bit means the difference went negative; fold back by +P.
    assign d12    = {1'b0, x1} - {1'b0, x2};
    assign d21    = {1'b0, x2} - {1'b0, x1};
    assign x1_sub = d12[BW_GF] ? d12[BW_GF-1:0] + P_192 : d12[BW_GF-1:0];
    assign x2_sub = d21[BW_GF] ? d21[BW_GF-1:0] + P_192 : d21[BW_GF-1:0];

`ifdef MOD_INV_CONST_TIME_EN
    logic [ITER_W-1:0] iter_cnt;
    logic              run_last;

    assign run_last = (iter_cnt == ITER_W'(MAX_ITER - 1));

    always_ff @(posedge clk) begin
        if (rst || state != RUN) iter_cnt <= '0;
        else                     iter_cnt <= iter_cnt + ITER_W'(1);
    end
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nxt = state;
        u_nxt     = u;
        v_nxt     = v;
        x1_nxt    = x1;
        x2_nxt    = x2;
        out_nxt   = out;
        err_nxt   = err;

        case (state)
            IDLE: begin
                if (start) begin
                    if (a == '0 || a >= P_192) begin
                        out_nxt   = '0;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        u_nxt     = a;
                        v_nxt     = P_192;
                        x1_nxt    = BW_GF'(1);
                        x2_nxt    = '0;
                        err_nxt   = 1'b0;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                // Once u or v reaches 1 the registers stop changing, so the padded
                // constant-time tail simply re-selects the same result each cycle.
                if (u == BW_GF'(1)) begin
                    out_nxt   = x1;
                    state_nxt = DONE;
                end else if (v == BW_GF'(1)) begin
                    out_nxt   = x2;
                    state_nxt = DONE;
                end else if (!u[0]) begin
                    u_nxt  = u >> 1;
                    x1_nxt = x1_half;
                end else if (!v[0]) begin
                    v_nxt  = v >> 1;
                    x2_nxt = x2_half;
                end else if (u >= v) begin
                    u_nxt  = u - v;
                    x1_nxt = x1_sub;
                end else begin
                    v_nxt  = v - u;
                    x2_nxt = x2_sub;
                end
`ifdef MOD_INV_CONST_TIME_EN
                state_nxt = run_last ? DONE : RUN;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
            out   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            u     <= u_nxt;
            v     <= v_nxt;
            x1    <= x1_nxt;
            x2    <= x2_nxt;
            out   <= out_nxt;
            err   <= err_nxt;
        end
    end

    assign valid = (state == DONE);
    assign busy  = (state != IDLE);

endmodule
